// File: rtl/wei_distributor_pkg.sv
// Shared types and default sizing for the weight distributor.
// Pulled into the interface, the top level and the testbench.
package wei_distributor_pkg;

    localparam int DEF_DATA_WIDTH  = 8;
    localparam int DEF_BLOCK_DEPTH = 32;
    localparam int DEF_KERNEL_SIZE = 9;
    localparam int DEF_WORD_NUM    = 8;
    localparam int DEF_ADDR_WIDTH  = 10;

    typedef enum logic [2:0] {
        IDLE,
        RDFLG,
        CNT,
        FETCH,
        WAITGET
    } state_e;

endpackage

// File: rtl/wei_distributor_if.sv
// Read ports of the flag GBF and the weight GBF.
// The distributor is the master; the buffers are the slave.
interface wei_distributor_if
    import wei_distributor_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int FLG_WIDTH  = DEF_BLOCK_DEPTH * DEF_KERNEL_SIZE,
    parameter int WEI_WIDTH  = DEF_DATA_WIDTH * DEF_WORD_NUM
);

    logic                  GBFFLGWEI_Val;
    logic                  GBFFLGWEI_EnRd;
    logic [ADDR_WIDTH-1:0] GBFFLGWEI_AddrRd;
    logic [FLG_WIDTH-1:0]  GBFFLGWEI_DatRd;
    logic                  GBFWEI_Val;
    logic                  GBFWEI_EnRd;
    logic [ADDR_WIDTH-1:0] GBFWEI_AddrRd;
    logic [WEI_WIDTH-1:0]  GBFWEI_DatRd;

    modport master (
        input  GBFFLGWEI_Val, GBFFLGWEI_DatRd,
        input  GBFWEI_Val, GBFWEI_DatRd,
        output GBFFLGWEI_EnRd, GBFFLGWEI_AddrRd,
        output GBFWEI_EnRd, GBFWEI_AddrRd
    );

    modport slave (
        output GBFFLGWEI_Val, GBFFLGWEI_DatRd,
        output GBFWEI_Val, GBFWEI_DatRd,
        input  GBFFLGWEI_EnRd, GBFFLGWEI_AddrRd,
        input  GBFWEI_EnRd, GBFWEI_AddrRd
    );

endinterface

// File: rtl/wei_distributor_popcount.sv
// Combinational population count built as a balanced adder tree.
// Input is zero-padded up to the next power of two.
module wei_popcount #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0]         din,
    output logic [$clog2(WIDTH+1)-1:0] cnt
);

    localparam int OW = $clog2(WIDTH + 1);
    localparam int LG = $clog2(WIDTH);
    localparam int P  = 1 << LG;

    for (genvar l = 0; l <= LG; l++) begin : g_lvl
        logic [OW-1:0] s [P >> l];
        for (genvar i = 0; i < (P >> l); i++) begin : g_node
            if (l == 0) begin : g_leaf
                if (i < WIDTH) begin : g_bit
                    assign s[i] = OW'(din[i]);
                end else begin : g_pad
                    assign s[i] = '0;
                end
            end else begin : g_sum
                assign s[i] = g_lvl[l-1].s[2*i] + g_lvl[l-1].s[2*i+1];
            end
        end
    end

    assign cnt = g_lvl[LG].s[0];

endmodule

// File: rtl/wei_distributor.sv
// Fetches a sparsity-flag word, then packs the nonzero weights of one
// block from the weight GBF, carrying leftover weights between blocks.
module wei_distributor
    import wei_distributor_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int BLOCK_DEPTH = DEF_BLOCK_DEPTH,
    parameter int KERNEL_SIZE = DEF_KERNEL_SIZE,
    parameter int WORD_NUM    = DEF_WORD_NUM,
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    localparam int NW = BLOCK_DEPTH * KERNEL_SIZE,
    localparam int CW = $clog2(NW + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     CTRLWEI_PlsFetch,
    input  logic                     CTRLWEI_GetWei,
    input  logic                     CTRLWEI_ClrAddr,
    output logic                     DISWEI_RdyWei,
    output logic [DATA_WIDTH*NW-1:0] DISWEIPEC_Wei,
    output logic [NW-1:0]            DISWEIPEC_FlgWei,
    output logic [CW-1:0]            DISWEIPEC_ValNum,
    wei_distributor_if.master        gbf
);

    localparam int PW = $clog2(NW + WORD_NUM + 1);

    state_e                               state_q, state_d;
    logic [ADDR_WIDTH-1:0]                faddr_q, faddr_d;
    logic [ADDR_WIDTH-1:0]                waddr_q, waddr_d;
    logic [NW-1:0]                        flg_q, flg_d;
    logic [CW-1:0]                        vnum_q, vnum_d;
    logic [PW-1:0]                        need_q, need_d;
    logic [PW-1:0]                        iss_q, iss_d;
    logic [PW-1:0]                        got_q, got_d;
    logic [PW-1:0]                        ptr_q, ptr_d;
    logic [PW-1:0]                        rmn_q, rmn_d;
    logic                                 pend_q, pend_d;
    logic [NW-1:0][DATA_WIDTH-1:0]        wei_q, wei_d;
    logic [WORD_NUM-1:0][DATA_WIDTH-1:0]  res_q, res_d;
    logic [WORD_NUM-1:0][DATA_WIDTH-1:0]  word;
    logic [CW-1:0]                        pop;
    logic [PW-1:0]                        vn_ext, vnx, diff, ptr_min;
    logic                                 flg_rd, wei_rd;

    wei_popcount #(.WIDTH(NW)) u_pop (
        .din (gbf.GBFFLGWEI_DatRd),
        .cnt (pop)
    );

    assign word    = gbf.GBFWEI_DatRd;
    assign vn_ext  = PW'(pop);
    assign vnx     = PW'(vnum_q);
    assign diff    = (vn_ext > rmn_q) ? vn_ext - rmn_q : '0;
    assign ptr_min = (diff == '0) ? vn_ext : rmn_q;
    assign flg_rd  = (state_q == RDFLG) && gbf.GBFFLGWEI_Val;
    assign wei_rd  = (state_q == FETCH) && gbf.GBFWEI_Val
                     && (iss_q < need_q);

    always_comb begin
        state_d = state_q;
        faddr_d = faddr_q + ADDR_WIDTH'(flg_rd);
        waddr_d = waddr_q + ADDR_WIDTH'(wei_rd);
        flg_d   = flg_q;
        vnum_d  = vnum_q;
        need_d  = need_q;
        iss_d   = iss_q + PW'(wei_rd);
        got_d   = got_q;
        ptr_d   = ptr_q;
        rmn_d   = rmn_q;
        pend_d  = wei_rd;
        wei_d   = wei_q;
        res_d   = res_q;
        unique case (state_q)
            IDLE: begin
                if (CTRLWEI_ClrAddr) begin
                    faddr_d = '0;
                    waddr_d = '0;
                    rmn_d   = '0;
                end
                if (CTRLWEI_PlsFetch) state_d = RDFLG;
            end
            RDFLG: begin
                if (flg_rd) state_d = CNT;
            end
            CNT: begin
                flg_d  = gbf.GBFFLGWEI_DatRd;
                vnum_d = pop;
                need_d = (diff + PW'(WORD_NUM - 1)) / PW'(WORD_NUM);
                iss_d  = '0;
                got_d  = '0;
                ptr_d  = ptr_min;
                wei_d  = '0;
                for (int k = 0; k < WORD_NUM; k++)
                    if (PW'(k) < ptr_min) wei_d[k] = res_q[k];
                // block fully served by leftovers: shift them down
                if (diff == '0) begin
                    rmn_d = rmn_q - vn_ext;
                    for (int r = 0; r < WORD_NUM; r++)
                        for (int s = 0; s < WORD_NUM; s++)
                            if (PW'(s) == PW'(r) + vn_ext)
                                res_d[r] = res_q[s];
                end
                state_d = FETCH;
            end
            FETCH: begin
                if (pend_q) begin
                    for (int k = 0; k < NW; k++)
                        for (int j = 0; j < WORD_NUM; j++)
                            if (PW'(k) == ptr_q + PW'(j) && PW'(k) < vnx)
                                wei_d[k] = word[j];
                    for (int r = 0; r < WORD_NUM; r++)
                        for (int j = 0; j < WORD_NUM; j++)
                            if (ptr_q + PW'(j) == vnx + PW'(r))
                                res_d[r] = word[j];
                    got_d = got_q + 1'b1;
                    ptr_d = ptr_q + PW'(WORD_NUM);
                    if (got_q + 1'b1 == need_q) begin
                        rmn_d   = ptr_q + PW'(WORD_NUM) - vnx;
                        state_d = WAITGET;
                    end
                end
                if (need_q == '0) state_d = WAITGET;
            end
            WAITGET: begin
                if (CTRLWEI_GetWei)
                    state_d = CTRLWEI_PlsFetch ? RDFLG : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            faddr_q <= '0;
            waddr_q <= '0;
            flg_q   <= '0;
            vnum_q  <= '0;
            need_q  <= '0;
            iss_q   <= '0;
            got_q   <= '0;
            ptr_q   <= '0;
            rmn_q   <= '0;
            pend_q  <= 1'b0;
            wei_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            faddr_q <= faddr_d;
            waddr_q <= waddr_d;
            flg_q   <= flg_d;
            vnum_q  <= vnum_d;
            need_q  <= need_d;
            iss_q   <= iss_d;
            got_q   <= got_d;
            ptr_q   <= ptr_d;
            rmn_q   <= rmn_d;
            pend_q  <= pend_d;
            wei_q   <= wei_d;
            res_q   <= res_d;
        end
    end

    assign DISWEI_RdyWei        = (state_q == WAITGET);
    assign DISWEIPEC_Wei        = wei_q;
    assign DISWEIPEC_FlgWei     = flg_q;
    assign DISWEIPEC_ValNum     = vnum_q;
    assign gbf.GBFFLGWEI_EnRd   = flg_rd;
    assign gbf.GBFFLGWEI_AddrRd = faddr_q;
    assign gbf.GBFWEI_EnRd      = wei_rd;
    assign gbf.GBFWEI_AddrRd    = waddr_q;

endmodule

// File: tb/tb_wei_distributor.sv
// Bench for wei_distributor: GBF memory models plus a weight-stream
// reference model that hands out nonzero weights in order.
module tb_wei_distributor;
    import wei_distributor_pkg::*;

    localparam int DW    = 8;
    localparam int WN    = 8;
    localparam int AW    = 10;
    localparam int NW    = 288;
    localparam int CW    = 9;
    localparam int DEPTH = 1 << AW;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             pls = 1'b0;
    logic             get = 1'b0;
    logic             clr = 1'b0;
    logic             rdy;
    logic [DW*NW-1:0] wei;
    logic [NW-1:0]    flg;
    logic [CW-1:0]    vnum;

    wei_distributor_if #(
        .ADDR_WIDTH (AW),
        .FLG_WIDTH  (NW),
        .WEI_WIDTH  (DW*WN)
    ) gbf ();

    wei_distributor u_dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .CTRLWEI_PlsFetch (pls),
        .CTRLWEI_GetWei   (get),
        .CTRLWEI_ClrAddr  (clr),
        .DISWEI_RdyWei    (rdy),
        .DISWEIPEC_Wei    (wei),
        .DISWEIPEC_FlgWei (flg),
        .DISWEIPEC_ValNum (vnum),
        .gbf              (gbf)
    );

    always #5 clk = ~clk;

    logic [NW-1:0]    fmem [DEPTH];
    logic [DW*WN-1:0] wmem [DEPTH];

    always @(posedge clk) begin
        if (gbf.GBFFLGWEI_EnRd)
            gbf.GBFFLGWEI_DatRd <= fmem[gbf.GBFFLGWEI_AddrRd];
        if (gbf.GBFWEI_EnRd)
            gbf.GBFWEI_DatRd <= wmem[gbf.GBFWEI_AddrRd];
    end

    int checks = 0;
    int errors = 0;
    int nrd;

    // reference model: addresses and a FIFO of not-yet-used weights
    int               m_fa, m_wa;
    logic [DW-1:0]    resq [$];
    int               exp_vn, exp_need, exp_fa, exp_wa;
    logic [NW-1:0]    exp_flg;
    logic [DW*NW-1:0] exp_wei;

    typedef struct {
        int nones;
        bit stall;
        bit b2b;
        int need;
        int lat;
        int rmn;
    } vec_t;
    vec_t tbl [10];

    task automatic chk(input string nm, input logic [NW-1:0] a,
                       input logic [NW-1:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, a, e);
        end
    endtask

    task automatic chk_wei(input string nm);
        int k;
        checks++;
        if (wei !== exp_wei) begin
            errors++;
            k = 0;
            while (k < NW - 1 && wei[k*DW +: DW] === exp_wei[k*DW +: DW])
                k++;
            $display("FAIL %s lane %0d: got %0h expected %0h", nm, k,
                     wei[k*DW +: DW], exp_wei[k*DW +: DW]);
        end
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_rdy"}, rdy, 0);
        chk({nm, "_wei"}, |wei, 0);
        chk({nm, "_flg"}, flg, 0);
        chk({nm, "_vnum"}, vnum, 0);
        chk({nm, "_fen"}, gbf.GBFFLGWEI_EnRd, 0);
        chk({nm, "_wen"}, gbf.GBFWEI_EnRd, 0);
        chk({nm, "_fad"}, gbf.GBFFLGWEI_AddrRd, 0);
        chk({nm, "_wad"}, gbf.GBFWEI_AddrRd, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NW-1:0] mkflags(input int n);
        logic [NW-1:0] f;
        f = '0;
        if (n >= NW) f = '1;
        else while ($countones(f) < n) f[$urandom_range(NW-1, 0)] = 1'b1;
        return f;
    endfunction

    task automatic prep(input logic [NW-1:0] f);
        logic [DW*WN-1:0] w;
        fmem[m_fa] = f;
        exp_flg  = f;
        exp_vn   = $countones(f);
        exp_fa   = m_fa;
        exp_wa   = m_wa;
        exp_need = 0;
        while (resq.size() < exp_vn) begin
            w = wmem[m_wa];
            for (int j = 0; j < WN; j++) resq.push_back(w[j*DW +: DW]);
            m_wa = (m_wa + 1) % DEPTH;
            exp_need++;
        end
        exp_wei = '0;
        for (int k = 0; k < exp_vn; k++) exp_wei[k*DW +: DW] = resq.pop_front();
        m_fa = (m_fa + 1) % DEPTH;
    endtask

    task automatic issue(input bit with_get);
        pls = 1'b1;
        get = with_get;
        tick();
        pls = 1'b0;
        get = 1'b0;
    endtask

    task automatic release_blk();
        get = 1'b1;
        tick();
        get = 1'b0;
        #1;
        chk("rdy_fall", rdy, 0);
    endtask

    task automatic finish(input bit stall, input int exp_lat);
        int n;
        bit seen;
        bit done;
        n = 1;
        seen = 0;
        done = 0;
        nrd = 0;
        #1;
        chk("rdy_low_t1", rdy, 0);
        chk("flg_en_t1", gbf.GBFFLGWEI_EnRd, 1);
        chk("flg_addr", gbf.GBFFLGWEI_AddrRd, exp_fa);
        while (!done && n < 120) begin
            gbf.GBFWEI_Val = !(stall && n >= 4 && n < 7);
            #1;
            if (gbf.GBFWEI_EnRd) begin
                if (!seen) chk("wei_addr", gbf.GBFWEI_AddrRd, exp_wa);
                seen = 1;
                nrd++;
            end
            if (rdy) done = 1;
            else begin
                tick();
                n++;
            end
        end
        gbf.GBFWEI_Val = 1'b1;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL rdy_timeout: got no RdyWei expected cycle %0d", exp_lat);
        end
        chk("latency", n, exp_lat);
        chk("wei_reads", nrd, exp_need);
        repeat (2) begin
            tick();
            chk("rdy_hold", rdy, 1);
        end
        chk("valnum", vnum, exp_vn);
        chk("flgwei", flg, exp_flg);
        chk_wei("wei");
        chk("rmn", u_dut.rmn_q, resq.size());
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NW-1:0] f;
        int nones;
        bit b2b, st;

        tbl[0] = '{9,   0, 0, 2,  6,  7};
        tbl[1] = '{3,   0, 0, 0,  4,  4};
        tbl[2] = '{0,   0, 1, 0,  4,  4};
        tbl[3] = '{20,  1, 0, 2,  9,  0};
        tbl[4] = '{1,   0, 1, 1,  5,  7};
        tbl[5] = '{288, 0, 0, 36, 40, 7};
        tbl[6] = '{7,   0, 1, 0,  4,  0};
        tbl[7] = '{8,   0, 0, 1,  5,  0};
        tbl[8] = '{9,   1, 0, 2,  9,  7};
        tbl[9] = '{15,  0, 1, 1,  5,  0};

        for (int i = 0; i < DEPTH; i++) begin
            wmem[i] = {$urandom, $urandom};
            fmem[i] = '0;
        end
        m_fa = 0;
        m_wa = 0;
        gbf.GBFFLGWEI_Val = 1'b1;
        gbf.GBFWEI_Val    = 1'b1;

        repeat (3) tick();
        chk_zero("reset");
        rst_n = 1'b1;
        tick();
        chk_zero("idle");

        for (int i = 0; i < 10; i++) begin
            f = mkflags(tbl[i].nones);
            if (i > 0 && tbl[i].b2b) begin
                prep(f);
                issue(1);
            end else begin
                if (i > 0) release_blk();
                prep(f);
                issue(0);
            end
            finish(tbl[i].stall, tbl[i].lat);
            chk("tbl_need", nrd, tbl[i].need);
            chk("tbl_rmn", u_dut.rmn_q, tbl[i].rmn);
        end

        // ClrAddr ignored outside IDLE, honoured in IDLE
        release_blk();
        prep(mkflags(1));
        issue(0);
        finish(0, 5);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        release_blk();
        chk("clr_ignored_rmn", u_dut.rmn_q, resq.size());
        clr = 1'b1;
        tick();
        clr = 1'b0;
        m_fa = 0;
        m_wa = 0;
        resq.delete();
        chk("clr_rmn", u_dut.rmn_q, 0);
        prep(mkflags(3));
        issue(0);
        finish(0, 5);

        // full blocks drive the weight address through its wrap
        for (int b = 0; b < 30; b++) begin
            release_blk();
            prep(mkflags(NW));
            issue(0);
            finish(0, 4 + exp_need);
        end

        // reset while fetching abandons the block
        release_blk();
        prep(mkflags(NW));
        issue(0);
        repeat (4) tick();
        chk("mid_fetch_en", gbf.GBFWEI_EnRd, 1);
        rst_n = 1'b0;
        #1;
        chk_zero("rst_mid");
        repeat (2) tick();
        chk_zero("rst_hold");
        rst_n = 1'b1;
        m_fa = 0;
        m_wa = 0;
        resq.delete();
        tick();
        prep(mkflags(5));
        issue(0);
        finish(0, 5);

        for (int r = 0; r < 40; r++) begin
            nones = ($urandom_range(3, 0) == 0) ? $urandom_range(NW, 0)
                                                 : $urandom_range(20, 0);
            f = mkflags(nones);
            b2b = 1'($urandom_range(1, 0));
            if (b2b) begin
                prep(f);
                issue(1);
            end else begin
                release_blk();
                prep(f);
                issue(0);
            end
            st = ($urandom_range(1, 0) == 1) && (exp_need >= 2);
            finish(st, 4 + exp_need + (st ? 3 : 0));
            if ($urandom_range(3, 0) == 0) begin
                clr = 1'b1;
                tick();
                clr = 1'b0;
                chk("clr_wait_rdy", rdy, 1);
            end
        end
        release_blk();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
